// File: rtl/lsu_mem_port.sv
// RV32I memory-stage load/store unit: one outstanding request on a request/ready
// data port, with pipeline stall, load extension and fault reporting.
module lsu_mem_port #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  fun3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        lsu_valid,
  output logic [31:0] load_data,
  output logic [1:0]  fault
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  localparam logic [1:0] F_OK    = 2'b00;
  localparam logic [1:0] F_ALIGN = 2'b01;
  localparam logic [1:0] F_ILL   = 2'b10;
  localparam logic [1:0] F_TMO   = 2'b11;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] ld_q, ld_d;
  logic        valid_q, valid_d;
  logic [1:0]  fault_q, fault_d;

  logic        illegal, misaligned;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  always_comb begin
    illegal = 1'b0;
    if (load && store) illegal = 1'b1;
    else if (load)  illegal = !(fun3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    else if (store) illegal = !(fun3 inside {3'b000, 3'b001, 3'b010});
    misaligned = ((fun3[1:0] == 2'b01) && addr[0]) ||
                 ((fun3 == 3'b010) && (addr[1:0] != 2'b00));
  end

  // Store lanes are replicated so the memory only has to honour the strobes.
  always_comb begin
    case (fun3)
      3'b000: begin
        wstrb_c = 4'b0001 << addr[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      3'b001: begin
        wstrb_c = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{store_data[15:0]}};
      end
      default: begin
        wstrb_c = 4'b1111;
        wdata_c = store_data;
      end
    endcase
  end

  always_comb begin
    case (lo_q)
      2'b00:   rd_byte = mem_rdata[7:0];
      2'b01:   rd_byte = mem_rdata[15:8];
      2'b10:   rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
      3'b100:  rd_ext = {24'h0, rd_byte};
      3'b101:  rd_ext = {16'h0, rd_half};
      default: rd_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    f3_d    = f3_q;
    lo_d    = lo_q;
    ld_d    = ld_q;
    valid_d = 1'b0;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (load || store) begin
          if (illegal) begin
            state_d = DONE;
            valid_d = 1'b1;
            fault_d = F_ILL;
            ld_d    = 32'h0;
          end else if (misaligned) begin
            state_d = DONE;
            valid_d = 1'b1;
            fault_d = F_ALIGN;
            ld_d    = 32'h0;
          end else begin
            state_d = BUSY;
            req_d   = 1'b1;
            we_d    = store;
            addr_d  = {addr[31:2], 2'b00};
            wdata_d = wdata_c;
            wstrb_d = store ? wstrb_c : 4'b0000;
            f3_d    = fun3;
            lo_d    = addr[1:0];
            cnt_d   = 8'd0;
          end
        end
      end
      BUSY: begin
        if (mem_ready) begin
          state_d = DONE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          fault_d = F_OK;
          ld_d    = we_q ? 32'h0 : rd_ext;
        end else if (cnt_q == TMO_LAST) begin
          state_d = DONE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          fault_d = F_TMO;
          ld_d    = 32'h0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'b0000;
      f3_q    <= 3'b000;
      lo_q    <= 2'b00;
      ld_q    <= 32'h0;
      valid_q <= 1'b0;
      fault_q <= F_OK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      f3_q    <= f3_d;
      lo_q    <= lo_d;
      ld_q    <= ld_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  // Stall must rise in the accept cycle, so it cannot wait for a register.
  assign stall = !rst && ((state_q == BUSY) || ((state_q == IDLE) && (load || store)));

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wstrb = wstrb_q;
  assign lsu_valid = valid_q;
  assign load_data = ld_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with TIMEOUT=4; expected values are hand-computed.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0, store = 1'b0;
  logic [2:0]  fun3 = 3'b000;
  logic [31:0] addr = 32'h0, store_data = 32'h0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        stall, lsu_valid;
  logic [31:0] load_data;
  logic [1:0]  fault;

  lsu_mem_port #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .load(load), .store(store), .fun3(fun3), .addr(addr),
    .store_data(store_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .stall(stall), .lsu_valid(lsu_valid),
    .load_data(load_data), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  int          n_stall, n_req, v_cyc;
  logic [1:0]  o_fault;
  logic [31:0] o_ld, o_addr, o_wdata;
  logic [3:0]  o_wstrb;
  logic        o_we;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // dly = index of the BUSY cycle that sees mem_ready (-1: never)
  task automatic run_op(input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd,
                        input int dly, input logic [31:0] rd);
    @(posedge clk); #1;
    load = ld; store = st; fun3 = f3; addr = a; store_data = sd;
    n_stall = 0; n_req = 0; v_cyc = -1;
    o_fault = 2'bxx; o_ld = 'x; o_addr = 'x; o_wdata = 'x; o_wstrb = 'x; o_we = 1'bx;
    for (int i = 0; i < 40 && v_cyc < 0; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      if (stall) n_stall++;
      if (mem_req) begin
        if (n_req == 0) begin
          o_addr = mem_addr; o_wdata = mem_wdata; o_wstrb = mem_wstrb; o_we = mem_we;
        end
        if (n_req == dly) begin
          mem_ready = 1'b1;
          mem_rdata = rd;
        end
        n_req++;
      end
      if (lsu_valid) begin
        v_cyc = i; o_fault = fault; o_ld = load_data;
        load = 1'b0; store = 1'b0;
      end
    end
    mem_ready = 1'b0;
    load = 1'b0; store = 1'b0;
    chk("valid_seen", 32'(v_cyc >= 0), 32'd1);
  endtask

  initial begin
    int extra_valid;
    #2;
    chk("rst_req",   32'(mem_req),   32'd0);
    chk("rst_stall", 32'(stall),     32'd0);
    chk("rst_valid", 32'(lsu_valid), 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_ldata", load_data,      32'd0);
    @(negedge clk); rst = 1'b0;

    // mem_ready while idle must not trigger anything
    mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    extra_valid = 0;
    repeat (3) begin
      @(negedge clk);
      if (lsu_valid || stall || mem_req) extra_valid++;
    end
    mem_ready = 1'b0;
    chk("idle_ready_ignored", 32'(extra_valid), 32'd0);

    run_op(1, 0, 3'b000, 32'h0000_1003, 32'h0, 0, 32'h80FF_1234);
    chk("lb_data",  o_ld,            32'hFFFF_FF80);
    chk("lb_fault", 32'(o_fault),    32'd0);
    chk("lb_vcyc",  32'(v_cyc),      32'd2);
    chk("lb_stall", 32'(n_stall),    32'd2);
    chk("lb_addr",  o_addr,          32'h0000_1000);
    chk("lb_wstrb", 32'(o_wstrb),    32'd0);

    run_op(0, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 0, 32'h0);
    chk("sh_we",    32'(o_we),       32'd1);
    chk("sh_addr",  o_addr,          32'h0000_2000);
    chk("sh_wstrb", 32'(o_wstrb),    32'hC);
    chk("sh_wdata", o_wdata,         32'hABCD_ABCD);
    chk("sh_ldata", o_ld,            32'h0);

    run_op(1, 0, 3'b010, 32'h0000_0006, 32'h0, 0, 32'h0);
    chk("lwmis_req",   32'(n_req),   32'd0);
    chk("lwmis_vcyc",  32'(v_cyc),   32'd1);
    chk("lwmis_fault", 32'(o_fault), 32'd1);
    chk("lwmis_stall", 32'(n_stall), 32'd1);

    run_op(1, 0, 3'b101, 32'h0000_0006, 32'h0, 0, 32'hBEEF_0000);
    chk("lhu_data",  o_ld,           32'h0000_BEEF);
    chk("lhu_fault", 32'(o_fault),   32'd0);

    run_op(1, 1, 3'b010, 32'h0000_0010, 32'h0, 0, 32'h0);
    chk("ill_both_fault", 32'(o_fault), 32'd2);
    chk("ill_both_req",   32'(n_req),   32'd0);

    run_op(1, 0, 3'b011, 32'h0000_0010, 32'h0, 0, 32'h0);
    chk("ill_f3_fault", 32'(o_fault), 32'd2);
    chk("ill_f3_req",   32'(n_req),   32'd0);

    run_op(1, 0, 3'b010, 32'h0000_0010, 32'h0, -1, 32'h0);
    chk("tmo_req",   32'(n_req),   32'd4);
    chk("tmo_fault", 32'(o_fault), 32'd3);
    chk("tmo_ldata", o_ld,         32'h0);
    chk("tmo_vcyc",  32'(v_cyc),   32'd5);

    run_op(1, 0, 3'b010, 32'h0000_0010, 32'h0, 2, 32'h1234_5678);
    chk("lw_data",  o_ld,          32'h1234_5678);
    chk("lw_fault", 32'(o_fault),  32'd0);
    chk("lw_stall", 32'(n_stall),  32'd4);
    chk("lw_req",   32'(n_req),    32'd3);

    run_op(0, 1, 3'b000, 32'h0000_0031, 32'h1234_565A, 0, 32'h0);
    chk("sb_addr",  o_addr,        32'h0000_0030);
    chk("sb_wstrb", 32'(o_wstrb),  32'h2);
    chk("sb_wdata", o_wdata,       32'h5A5A_5A5A);

    run_op(1, 0, 3'b001, 32'h0000_0002, 32'h0, 0, 32'h8001_0000);
    chk("lh_data", o_ld, 32'hFFFF_8001);

    run_op(1, 0, 3'b100, 32'h0000_0001, 32'h0, 1, 32'h0000_9000);
    chk("lbu_data", o_ld, 32'h0000_0090);

    // reset asserted during the second BUSY cycle
    @(posedge clk); #1;
    load = 1'b1; fun3 = 3'b010; addr = 32'h0000_0040;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid_req_before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_req",   32'(mem_req),   32'd0);
    chk("mid_stall", 32'(stall),     32'd0);
    chk("mid_addr",  mem_addr,       32'h0);
    chk("mid_valid", 32'(lsu_valid), 32'd0);
    load = 1'b0;
    extra_valid = 0;
    repeat (2) begin
      @(negedge clk);
      if (lsu_valid) extra_valid++;
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (lsu_valid || mem_req) extra_valid++;
    end
    chk("mid_no_pulse", 32'(extra_valid), 32'd0);

    run_op(0, 1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 0, 32'h0);
    chk("sw_wstrb", 32'(o_wstrb),  32'hF);
    chk("sw_wdata", o_wdata,       32'hCAFE_F00D);
    chk("sw_addr",  o_addr,        32'h0000_0020);
    chk("sw_fault", 32'(o_fault),  32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
